// File: rtl/gemm_tile_sched.sv
// gemm_tile_sched
//   Splits a full GEMM job (M x K times K x N) into BLK_M x BLK_K x BLK_N tiles and programs
//   each tile into the GEMM register block over the system bus. Between tiles it polls the GEMM
//   full flag (+0 bit0). After the last tile it waits on the GEMM done flag (+24 bit0).
// Ports:
//   clk, rst                   clock; synchronous active-low reset
//   start                      one-cycle job launch, accepted only when idle
//   m_dim, k_dim, n_dim        full matrix dimensions
//   a_base, b_base, c_base     element base addresses of A, B and C (row-major)
//   busy, done, tile_cnt       job status; done is a one-cycle pulse
//   system_bus_*               register port towards the GEMM; rd_data arrives one cycle late
module gemm_tile_sched #(
    parameter int unsigned BLK_M     = 16,
    parameter int unsigned BLK_K     = 16,
    parameter int unsigned BLK_N     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
    parameter int unsigned DIM_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] m_dim,
    input  logic [DIM_W-1:0] k_dim,
    input  logic [DIM_W-1:0] n_dim,
    input  logic [31:0]      a_base,
    input  logic [31:0]      b_base,
    input  logic [31:0]      c_base,
    output logic             busy,
    output logic             done,
    output logic [15:0]      tile_cnt,
    output logic             system_bus_en,
    output logic             system_bus_rdwr,
    output logic [31:0]      system_bus_addr,
    output logic [31:0]      system_bus_wr_data,
    input  logic [31:0]      system_bus_rd_data
);

    typedef enum logic [2:0] {
        StIdle, StCfg, StPollWait, StPollFull, StNext, StDrainWait, StDrain, StFin
    } state_e;

    localparam logic [DIM_W:0] STEP_K = (DIM_W+1)'(BLK_K);
    localparam logic [DIM_W:0] STEP_M = (DIM_W+1)'(BLK_M);
    localparam logic [DIM_W:0] STEP_N = (DIM_W+1)'(BLK_N);

    state_e           state_q;
    logic [2:0]       beat_q;     // CFG beat currently on the bus
    logic [DIM_W-1:0] m_dim_q, k_dim_q, n_dim_q;
    logic [31:0]      a_base_q, b_base_q, c_base_q;
    logic [DIM_W-1:0] m_pos_q, k_pos_q, n_pos_q;
    logic [31:0]      mk_off_q;   // m * K
    logic [31:0]      mn_off_q;   // m * N
    logic [31:0]      kn_off_q;   // k * N

    logic [DIM_W:0]   k_end, m_end, n_end;
    logic             last_k, more_m, more_n, first_k;
    logic [DIM_W-1:0] rem_k, rem_m, rem_n;
    logic [4:0]       ksize, msize, nsize, kspan;
    logic [31:0]      k_dim_w, n_dim_w, mk_step, mn_step, kn_step;
    logic [31:0]      kspan_off, ta, tb, tc;
    logic [4:0]       cfg_off;
    logic [31:0]      cfg_data;
    logic             unused_rd_data;

    // Only the flag bit of a register read is meaningful here.
    assign unused_rd_data = ^system_bus_rd_data[31:1];

    assign k_dim_w = 32'(k_dim_q);
    assign n_dim_w = 32'(n_dim_q);
    assign mk_step = k_dim_w * BLK_M;
    assign mn_step = n_dim_w * BLK_M;
    assign kn_step = n_dim_w * BLK_K;

    assign k_end   = {1'b0, k_pos_q} + STEP_K;
    assign m_end   = {1'b0, m_pos_q} + STEP_M;
    assign n_end   = {1'b0, n_pos_q} + STEP_N;
    assign last_k  = k_end >= {1'b0, k_dim_q};
    assign more_m  = m_end < {1'b0, m_dim_q};
    assign more_n  = n_end < {1'b0, n_dim_q};
    assign first_k = k_pos_q == '0;

    // Remainders are only used on a final (partial) tile, where they fit a 5-bit field.
    assign rem_k = k_dim_q - k_pos_q;
    assign rem_m = m_dim_q - m_pos_q;
    assign rem_n = n_dim_q - n_pos_q;
    assign ksize = last_k ? rem_k[4:0] : 5'(BLK_K);
    assign msize = more_m ? 5'(BLK_M) : rem_m[4:0];
    assign nsize = more_n ? 5'(BLK_N) : rem_n[4:0];
    assign kspan = ksize - 5'd1;

    // (ksize-1)*N: at most five shifted copies of N, since ksize never exceeds BLK_K.
    always_comb begin
        kspan_off = '0;
        for (int i = 0; i < 5; i++) begin
            if (kspan[i]) kspan_off = kspan_off + (n_dim_w << i);
        end
    end

    assign ta = a_base_q + mk_off_q + 32'(k_pos_q);
    assign tb = b_base_q + 32'(n_pos_q) + kn_off_q + kspan_off;
    assign tc = c_base_q + 32'(n_pos_q) + mn_off_q;

    // Register offset and data of the beat that follows the one now on the bus.
    always_comb begin
        cfg_off  = 5'd0;
        cfg_data = '0;
        case (beat_q)
            3'd0:    begin cfg_off = 5'd16; cfg_data = n_dim_w;                          end
            3'd1:    begin cfg_off = 5'd0;  cfg_data = ta;                               end
            3'd2:    begin cfg_off = 5'd4;  cfg_data = tb;                               end
            3'd3:    begin cfg_off = 5'd8;  cfg_data = tc;                               end
            3'd4:    begin cfg_off = 5'd20; cfg_data = {30'd0, first_k, last_k};         end
            3'd5:    begin cfg_off = 5'd24; cfg_data = {17'd0, nsize, ksize, msize};     end
            default: begin cfg_off = 5'd0;  cfg_data = '0;                               end
        endcase
    end

    // Bus outputs are loaded on the edge that enters a state, so they line up with that state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q            <= StIdle;
            beat_q             <= '0;
            m_dim_q            <= '0;
            k_dim_q            <= '0;
            n_dim_q            <= '0;
            a_base_q           <= '0;
            b_base_q           <= '0;
            c_base_q           <= '0;
            m_pos_q            <= '0;
            k_pos_q            <= '0;
            n_pos_q            <= '0;
            mk_off_q           <= '0;
            mn_off_q           <= '0;
            kn_off_q           <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            tile_cnt           <= '0;
            system_bus_en      <= 1'b0;
            system_bus_rdwr    <= 1'b0;
            system_bus_addr    <= '0;
            system_bus_wr_data <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        m_dim_q  <= m_dim;
                        k_dim_q  <= k_dim;
                        n_dim_q  <= n_dim;
                        a_base_q <= a_base;
                        b_base_q <= b_base;
                        c_base_q <= c_base;
                        m_pos_q  <= '0;
                        k_pos_q  <= '0;
                        n_pos_q  <= '0;
                        mk_off_q <= '0;
                        mn_off_q <= '0;
                        kn_off_q <= '0;
                        busy     <= 1'b1;
                        tile_cnt <= '0;
                        if (m_dim == '0 || k_dim == '0 || n_dim == '0) begin
                            state_q <= StFin;
                        end else begin
                            state_q            <= StCfg;
                            beat_q             <= '0;
                            system_bus_en      <= 1'b1;
                            system_bus_rdwr    <= 1'b1;
                            system_bus_addr    <= BASE_ADDR + 32'd12;
                            system_bus_wr_data <= 32'(k_dim);
                        end
                    end
                end
                StCfg: begin
                    if (beat_q == 3'd6) begin
                        state_q            <= StPollWait;
                        system_bus_rdwr    <= 1'b0;
                        system_bus_addr    <= BASE_ADDR;
                        system_bus_wr_data <= '0;
                    end else begin
                        beat_q             <= beat_q + 3'd1;
                        system_bus_addr    <= BASE_ADDR + 32'(cfg_off);
                        system_bus_wr_data <= cfg_data;
                        if (beat_q == 3'd5) tile_cnt <= tile_cnt + 16'd1;
                    end
                end
                StPollWait: state_q <= StPollFull;
                StPollFull: begin
                    if (!system_bus_rd_data[0]) begin
                        state_q         <= StNext;
                        system_bus_en   <= 1'b0;
                        system_bus_addr <= '0;
                    end
                end
                StNext: begin
                    // k innermost, then m, then n.
                    if (!last_k) begin
                        k_pos_q  <= k_end[DIM_W-1:0];
                        kn_off_q <= kn_off_q + kn_step;
                    end else begin
                        k_pos_q  <= '0;
                        kn_off_q <= '0;
                        if (more_m) begin
                            m_pos_q  <= m_end[DIM_W-1:0];
                            mk_off_q <= mk_off_q + mk_step;
                            mn_off_q <= mn_off_q + mn_step;
                        end else begin
                            m_pos_q  <= '0;
                            mk_off_q <= '0;
                            mn_off_q <= '0;
                            if (more_n) n_pos_q <= n_end[DIM_W-1:0];
                        end
                    end
                    system_bus_en <= 1'b1;
                    if (!last_k || more_m || more_n) begin
                        state_q            <= StCfg;
                        beat_q             <= '0;
                        system_bus_rdwr    <= 1'b1;
                        system_bus_addr    <= BASE_ADDR + 32'd12;
                        system_bus_wr_data <= k_dim_w;
                    end else begin
                        state_q         <= StDrainWait;
                        system_bus_rdwr <= 1'b0;
                        system_bus_addr <= BASE_ADDR + 32'd24;
                    end
                end
                StDrainWait: state_q <= StDrain;
                StDrain: begin
                    if (system_bus_rd_data[0]) begin
                        state_q         <= StFin;
                        system_bus_en   <= 1'b0;
                        system_bus_addr <= '0;
                    end
                end
                StFin: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gemm_tile_sched.sv
// Bench for gemm_tile_sched: a job-level model pushes every expected register write and the
// final tile count into queues; a negedge monitor pops and compares whenever the DUT writes or
// pulses done, and also checks cycle timing of the poll / drain handshakes.
module tb_gemm_tile_sched;

    localparam logic [31:0] BASE = 32'h9000_0000;
    localparam int BM = 16;
    localparam int BK = 16;
    localparam int BN = 16;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] m_dim = '0, k_dim = '0, n_dim = '0;
    logic [31:0] a_base = '0, b_base = '0, c_base = '0;
    logic        busy, done;
    logic [15:0] tile_cnt;
    logic        sys_en, sys_rdwr;
    logic [31:0] sys_addr, sys_wdata;
    logic [31:0] rd_data = '0;

    gemm_tile_sched dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .m_dim              (m_dim),
        .k_dim              (k_dim),
        .n_dim              (n_dim),
        .a_base             (a_base),
        .b_base             (b_base),
        .c_base             (c_base),
        .busy               (busy),
        .done               (done),
        .tile_cnt           (tile_cnt),
        .system_bus_en      (sys_en),
        .system_bus_rdwr    (sys_rdwr),
        .system_bus_addr    (sys_addr),
        .system_bus_wr_data (sys_wdata),
        .system_bus_rd_data (rd_data)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wr_t exp_q[$];
    int  exp_done_q[$];
    int  checks = 0;
    int  passes = 0;
    int  first_due = -1;   // cycle of the first +12 write of a job
    int  zero_cyc = -1;    // cycle in which a full=0 poll sample was seen
    int  done_due = -1;    // cycle in which done must pulse
    bit  job_active = 0;
    bit  no_bus = 0;
    int  full_stalls = 0, drain_stalls = 0;
    int  full_cnt = 0, drain_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_evt(input string name);
        checks++;
        $display("FAIL %s: got event at cycle %0d, want none", name, cyc);
    endtask

    // GEMM register-port model: full flag holds for full_stalls samples per tile, done flag
    // appears after drain_stalls samples. Upper bits carry noise.
    logic [31:0] noise;
    always @(posedge clk) begin
        if (sys_en && sys_rdwr) begin
            full_cnt  <= 0;
            drain_cnt <= 0;
        end else if (sys_en) begin
            noise = $urandom();
            if (sys_addr == BASE) begin
                rd_data  <= {noise[31:1], full_cnt < full_stalls};
                full_cnt <= full_cnt + 1;
            end else if (sys_addr == BASE + 32'd24) begin
                rd_data   <= {noise[31:1], drain_cnt >= drain_stalls};
                drain_cnt <= drain_cnt + 1;
            end
        end
    end

    task automatic push(input int off, input logic [31:0] d);
        wr_t w;
        w.addr = BASE + 32'(off);
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Job-level reference: straight from the tiling rules with ordinary multiplication.
    task automatic model_job(input int m, input int k, input int n,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        int tiles;
        int ks, ms, ns;
        bit first, last;
        tiles = 0;
        if (m != 0 && k != 0 && n != 0) begin
            for (int nn = 0; nn < n; nn += BN) begin
                for (int mm = 0; mm < m; mm += BM) begin
                    for (int kk = 0; kk < k; kk += BK) begin
                        ks = (k - kk < BK) ? k - kk : BK;
                        ms = (m - mm < BM) ? m - mm : BM;
                        ns = (n - nn < BN) ? n - nn : BN;
                        first = (kk == 0);
                        last = (kk + BK >= k);
                        push(12, 32'(k));
                        push(16, 32'(n));
                        push(0, a + 32'(mm * k + kk));
                        push(4, b + 32'(nn + (kk + ks - 1) * n));
                        push(8, c + 32'(nn + mm * n));
                        push(20, {30'd0, first, last});
                        push(24, 32'(ms + ks * 32 + ns * 1024));
                        tiles++;
                    end
                end
            end
        end
        exp_done_q.push_back(tiles);
    endtask

    bit rd_now = 0, prev_rd = 0;
    logic [31:0] prev_addr = '0;
    wr_t got;

    always @(negedge clk) begin
        if (rst) begin
            rd_now = sys_en && !sys_rdwr;
            if (sys_en && sys_rdwr) begin
                if (exp_q.size() == 0) begin
                    fail_evt("unexpected_write");
                end else begin
                    got = exp_q.pop_front();
                    check("write_addr_data", {sys_addr, sys_wdata}, {got.addr, got.data});
                end
                if (sys_addr == BASE + 32'd12) begin
                    if (first_due >= 0) begin
                        check("start_to_first_beat", cyc, first_due);
                        first_due = -1;
                    end else if (zero_cyc >= 0) begin
                        check("poll_to_next_tile", cyc, zero_cyc + 2);
                        zero_cyc = -1;
                    end
                end
            end
            if (rd_now) begin
                check("rd_wdata_zero", sys_wdata, 0);
                if (sys_addr == BASE + 32'd24 && !prev_rd && zero_cyc >= 0) begin
                    check("poll_to_drain", cyc, zero_cyc + 2);
                    zero_cyc = -1;
                end
                if (prev_rd && sys_addr == prev_addr) begin
                    if (sys_addr == BASE && !rd_data[0]) zero_cyc = cyc;
                    if (sys_addr == BASE + 32'd24 && rd_data[0]) done_due = cyc + 2;
                end
            end
            if (!sys_en) check("idle_wdata_zero", sys_wdata, 0);
            if (done) begin
                if (exp_done_q.size() == 0) fail_evt("unexpected_done");
                else check("tile_cnt", tile_cnt, exp_done_q.pop_front());
                check("done_time", cyc, done_due);
                check("writes_drained", exp_q.size(), 0);
                check("busy_at_done", busy, 1'b0);
                done_due = -1;
                job_active = 0;
                no_bus = 0;
            end else if (done_due >= 0 && cyc > done_due) begin
                fail_evt("done_missing");
                done_due = -1;
            end
            if (job_active && !busy && !done) fail_evt("busy_dropped");
            if (no_bus && sys_en) fail_evt("zero_dim_bus");
            prev_rd = rd_now;
            prev_addr = sys_addr;
        end else begin
            prev_rd = 0;
        end
    end

    task automatic clear_tracking();
        exp_q.delete();
        exp_done_q.delete();
        job_active = 0;
        no_bus = 0;
        first_due = -1;
        zero_cyc = -1;
        done_due = -1;
    endtask

    task automatic launch(input int m, input int k, input int n, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c);
        model_job(m, k, n, a, b, c);
        @(posedge clk); #1;
        m_dim = 16'(m); k_dim = 16'(k); n_dim = 16'(n);
        a_base = a; b_base = b; c_base = c;
        start = 1'b1;
        if (m == 0 || k == 0 || n == 0) begin
            done_due = cyc + 2;
            no_bus = 1;
        end else begin
            first_due = cyc + 1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        job_active = 1;
        // The job is latched; these inputs must no longer matter.
        m_dim = 16'($urandom()); k_dim = 16'($urandom()); n_dim = 16'($urandom());
        a_base = $urandom(); b_base = $urandom(); c_base = $urandom();
    endtask

    task automatic wait_done(input int limit);
        int i;
        i = 0;
        while (job_active && i < limit) begin
            @(posedge clk);
            i++;
        end
        if (job_active) begin
            fail_evt("job_timeout");
            rst = 1'b0;
            @(posedge clk); #1;
            clear_tracking();
            rst = 1'b1;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic run_job(input int m, input int k, input int n, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] c, input int fs,
                           input int ds, input bit mid_start);
        full_stalls = fs;
        drain_stalls = ds;
        launch(m, k, n, a, b, c);
        if (mid_start) begin
            repeat (13) @(posedge clk);
            #1;
            m_dim = 16'd3; k_dim = 16'd5; n_dim = 16'd7;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_done(4000);
    endtask

    bit found;

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, tile_cnt, sys_en, sys_rdwr, sys_addr, sys_wdata}, '0);
        rst = 1'b1;

        run_job(16, 16, 16, 32'd0, 32'd256, 32'd512, 0, 0, 0);
        run_job(20, 20, 20, 32'd0, 32'd400, 32'd800, 5, 20, 1);
        run_job(0, 16, 16, 32'd0, 32'd256, 32'd512, 0, 0, 0);

        // Reset while the +4 beat is on the bus, then rerun the single tile.
        full_stalls = 0;
        drain_stalls = 0;
        launch(16, 16, 16, 32'd0, 32'd256, 32'd512);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (sys_en && sys_rdwr && sys_addr == BASE + 32'd4) found = 1;
        end
        check("reach_beat4", found, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_mid_job", {busy, done, tile_cnt, sys_en, sys_rdwr, sys_addr, sys_wdata}, '0);
        clear_tracking();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        run_job(16, 16, 16, 32'd0, 32'd256, 32'd512, 0, 0, 0);

        for (int j = 0; j < 6; j++) begin
            run_job($urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(1, 40),
                    $urandom(), $urandom(), $urandom(),
                    $urandom_range(0, 3), $urandom_range(0, 4), 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
